mc_control_unit: RTL

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/cpu_ctrl_pkg.sv | 51 +++++
 rtl/opcode_decoder.sv | 27 ++
 rtl/mc_control_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control types for the multi-cycle RV32I control unit:
// FSM state codes, opcode constants, opcode classes and the ctrl bundle.
package cpu_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_FETCH  = 3'd0;
    localparam state_t S_DECODE = 3'd1;
    localparam state_t S_EXEC   = 3'd2;
    localparam state_t S_MEM    = 3'd3;
    localparam state_t S_WB     = 3'd4;
    localparam state_t S_FAULT  = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_IALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_LUI,
        CL_AUIPC
    } op_class_t;

    typedef struct packed {
        logic ir_write;
        logic pc_write;
        logic reg_write;
        logic alusrc;
        logic branch;
        logic jump;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    // Second ALU operand comes from the immediate for these classes
    function automatic logic uses_imm(op_class_t c);
        return c inside {CL_IALU, CL_LOAD, CL_STORE, CL_LUI, CL_AUIPC};
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: maps a 7-bit RV32I opcode to its
// class and flags anything outside the supported subset as illegal.
module opcode_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output logic       legal
);

    always_comb begin
        op_class = CL_ALU;
        legal    = 1'b1;
        unique case (1'b1)
            (opcode == OP_R):      op_class = CL_ALU;
            (opcode == OP_I):      op_class = CL_IALU;
            (opcode == OP_LOAD):   op_class = CL_LOAD;
            (opcode == OP_STORE):  op_class = CL_STORE;
            (opcode == OP_BRANCH): op_class = CL_BRANCH;
            (opcode == OP_JAL):    op_class = CL_JAL;
            (opcode == OP_LUI):    op_class = CL_LUI;
            (opcode == OP_AUIPC):  op_class = CL_AUIPC;
            default:               legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM with memory-wait timeout, sticky fault
// and a wrapping retired-instruction counter.
module mc_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             stall,
    output logic             imem_req,
    output logic             dmem_req,
    output ctrl_t            ctrl,
    output logic [2:0]       state,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [6:0]       opcode_q;
    logic [TW-1:0]    tcnt_q;
    logic [CNT_W-1:0] ret_q;
    logic             retire;
    logic             wait_cyc;
    op_class_t        cls;
    logic             legal;

    opcode_decoder u_dec (
        .opcode   (opcode_q),
        .op_class (cls),
        .legal    (legal)
    );

    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        wait_cyc = 1'b0;
        if (!stall) begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        state_d = S_DECODE;
                    end else begin
                        wait_cyc = 1'b1;
                        if (tcnt_q == T_LAST) state_d = S_FAULT;
                    end
                end
                S_DECODE: state_d = legal ? S_EXEC : S_FAULT;
                S_EXEC: begin
                    if (cls == CL_BRANCH) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else if (cls == CL_LOAD || cls == CL_STORE) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (cls == CL_STORE) begin
                            state_d = S_FETCH;
                            retire  = 1'b1;
                        end else begin
                            state_d = S_WB;
                        end
                    end else begin
                        wait_cyc = 1'b1;
                        if (tcnt_q == T_LAST) state_d = S_FAULT;
                    end
                end
                S_WB: begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_FAULT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            tcnt_q   <= '0;
            ret_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && imem_ready && !stall) opcode_q <= opcode;
            // Counter restarts whenever a new state is entered
            if (state_d != state_q) tcnt_q <= '0;
            else if (wait_cyc) tcnt_q <= tcnt_q + TW'(1);
            if (retire) ret_q <= ret_q + CNT_W'(1);
        end
    end

    always_comb begin
        ctrl = '0;
        if (rst_n && !stall) begin
            case (state_q)
                S_FETCH: ctrl.ir_write = imem_ready;
                S_EXEC: begin
                    ctrl.alusrc   = uses_imm(cls);
                    ctrl.branch   = (cls == CL_BRANCH);
                    ctrl.pc_write = (cls == CL_BRANCH);
                    ctrl.jump     = (cls == CL_JAL);
                end
                S_MEM: begin
                    ctrl.mem_read  = (cls == CL_LOAD);
                    ctrl.mem_write = (cls == CL_STORE);
                    ctrl.pc_write  = (cls == CL_STORE) && dmem_ready;
                end
                S_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.pc_write   = 1'b1;
                    ctrl.mem_to_reg = (cls == CL_LOAD);
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign imem_req = rst_n && (state_q == S_FETCH);
    assign dmem_req = rst_n && (state_q == S_MEM);
    assign state    = state_q;
    assign fault    = (state_q == S_FAULT);
    assign retired  = ret_q;

endmodule
